uart_rx_byte: RTL and testbench

- Serial-to-parallel front end for the byte shift-register stage that sits directly downstream.
- Receives asynchronous 8N1 UART frames on a single input line and presents each recovered byte on data_out.
- Raises a clean one-cycle ready strobe per byte; the downstream stage uses ready as its shift edge.
- Reports bad stop bits and holds off re-arming during line breaks.

---
 rtl/uart_rx_byte.sv | 83 ++++++++
 tb/tb_uart_rx_byte.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with a one-cycle ready strobe, framing-error strobe and break hold-off
module uart_rx_byte #(
  parameter int data_size    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [data_size-1:0] data_out,
  output logic                 ready,
  output logic                 framing_error,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = data_size > 1 ? $clog2(data_size) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] TOP  = BW'(data_size - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE, BRK} state_t;
  state_t               state;
  logic [1:0]           sync;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [data_size-1:0] shreg;
  logic                 rx_s;
  assign rx_s = sync[1];
  // data_out loads on the STOP edge and ready follows one cycle later from DONE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync          <= 2'b11;
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      data_out      <= '0;
      ready         <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      sync          <= {sync[0], rx};
      ready         <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          busy <= ~rx_s;
          if (!rx_s) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= START;
          end
        end
        START:
          if (clk_cnt == HALF) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else clk_cnt <= clk_cnt + 1'b1;
        DATA:
          if (clk_cnt == LAST) begin
            clk_cnt        <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == TOP) state <= STOP;
          end else clk_cnt <= clk_cnt + 1'b1;
        STOP:
          if (clk_cnt == LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              data_out <= shreg;
              state    <= DONE;
            end else begin
              framing_error <= 1'b1;
              state         <= BRK;
            end
          end else clk_cnt <= clk_cnt + 1'b1;
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        BRK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: table-driven frames with a byte scoreboard, plus glitch, reset and downstream sequences
module tb_uart_rx_byte;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       ready, framing_error, busy;
  uart_rx_byte #(.data_size(8), .CLKS_PER_BIT(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out),
    .ready(ready), .framing_error(framing_error), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_hold;
    int         gap;
    logic [7:0] exp_dout;
  } vec_t;
  int n_vec = 0, n_err = 0, cyc = 0, rdy_cnt = 0, fe_cnt = 0, prev_rdy = 0, last_rdy = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  prev_dout = 8'h00;
  logic        prev_strobe = 1'b0;
  logic [15:0] ds = 16'h0000;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(16);
    end
    rx = stop;
    tick(16);
    rx = 1'b1;
  endtask
  always @(posedge clk) cyc++;
  // downstream depth-2 byte shift register clocked by ready, newest byte in the low slot
  always @(posedge ready or posedge reset)
    if (reset) ds <= 16'h0000;
    else ds <= {ds[7:0], data_out};
  always @(negedge clk) begin
    if (!reset) begin
      if (ready || framing_error) begin
        check("strobe_exclusive", {31'd0, ready & framing_error}, 32'd0);
        check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
      end
      if (ready) begin
        rdy_cnt++;
        prev_rdy = last_rdy;
        last_rdy = cyc;
        check("dout_stable_before_ready", {24'd0, prev_dout}, {24'd0, data_out});
        check("busy_during_ready", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ready_expected: ready with empty scoreboard, data_out=%0h", data_out);
        end else check("ready_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
      if (framing_error) fe_cnt++;
    end
    prev_dout   = data_out;
    prev_strobe = ready | framing_error;
  end
  initial begin
    vec_t vecs[5];
    int r0, f0, k;
    vecs[0] = '{8'hA5, 1'b1, 0, 20, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 0, 0, 8'h3C};
    vecs[2] = '{8'hC3, 1'b1, 0, 20, 8'hC3};
    vecs[3] = '{8'h55, 1'b0, 40, 20, 8'hC3};
    vecs[4] = '{8'h0F, 1'b1, 0, 20, 8'h0F};
    tick(3);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_framing_error", {31'd0, framing_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(10);
    for (int i = 0; i < 5; i++) begin
      r0 = rdy_cnt;
      f0 = fe_cnt;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].low_hold > 0) begin
        rx = 1'b0;
        tick(vecs[i].low_hold);
        check("break_quiet_ready", rdy_cnt - r0, 0);
        check("break_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
      end
      tick(vecs[i].gap);
      check("vec_ready_count", rdy_cnt - r0, {31'd0, vecs[i].stop});
      check("vec_fe_count", fe_cnt - f0, {31'd0, ~vecs[i].stop});
      check("vec_data_out", {24'd0, data_out}, {24'd0, vecs[i].exp_dout});
      if (vecs[i].gap > 0) check("vec_busy_idle", {31'd0, busy}, 32'd0);
      if (i == 2) begin
        n_vec++;
        if (last_rdy - prev_rdy < 158 || last_rdy - prev_rdy > 162) begin
          n_err++;
          $display("FAIL b2b_spacing: got %0d cycles expected 160+-2", last_rdy - prev_rdy);
        end
      end
    end
    r0 = rdy_cnt;
    f0 = fe_cnt;
    rx = 1'b0;
    tick(4);
    check("glitch_busy_seen", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    k = 0;
    while (busy && k < 10) begin
      tick(1);
      k++;
    end
    check("glitch_busy_drop", {31'd0, busy}, 32'd0);
    tick(20);
    check("glitch_no_ready", rdy_cnt - r0, 0);
    check("glitch_no_fe", fe_cnt - f0, 0);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      tick(16);
    end
    tick(8);
    check("midframe_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_framing_error", {31'd0, framing_error}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    tick(3);
    reset = 1'b0;
    tick(20);
    check("post_rst_idle", {31'd0, busy}, 32'd0);
    r0 = rdy_cnt;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick(20);
    check("post_rst_ready_count", rdy_cnt - r0, 1);
    check("post_rst_data_out", {24'd0, data_out}, 32'h81);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick(20);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    tick(20);
    check("downstream_shift", {16'd0, ds}, 32'h1122);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
